// File: rtl/cti_commit_queue_pkg.sv
// Shared definitions for the CTI commit queue: queue geometry, PC and
// branch-type widths, branch-type encodings and the stored entry layout.
package cti_commit_queue_pkg;

  localparam int unsigned SIZE_PC     = 32;
  localparam int unsigned BRANCH_TYPE = 2;
  localparam int unsigned CTI_DEPTH   = 16;
  localparam int unsigned CTI_INDEX   = 4;

  localparam logic [BRANCH_TYPE-1:0] COND   = 2'd0;
  localparam logic [BRANCH_TYPE-1:0] CALL   = 2'd1;
  localparam logic [BRANCH_TYPE-1:0] RETURN = 2'd2;
  localparam logic [BRANCH_TYPE-1:0] JUMP   = 2'd3;

  typedef struct packed {
    logic [SIZE_PC-1:0]     pc;
    logic [BRANCH_TYPE-1:0] br_type;
  } cti_entry_t;

endpackage

// File: rtl/cti_queue_ram.sv
// 1R1W storage for the CTI commit queue.
// Ports:
//   clk      - clock
//   we_i     - write enable
//   waddr_i  - write slot (queue tail)
//   wdata_i  - entry written on the clock edge
//   raddr_i  - read slot (queue head)
//   rdata_o  - combinational read data
module cti_queue_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned INDEX = 4,
  parameter int unsigned WIDTH = 34
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [INDEX-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [INDEX-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cti_commit_queue.sv
// In-order queue of control-transfer instructions between fetch-2 and retire.
// Entries are enqueued speculatively, marked committed in program order by
// retire, and drained one per cycle onto the predictor/RAS update bus.
// Flushes discard every uncommitted entry; committed ones keep draining.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   recoverFlag_i              - mispredict flush
//   exceptionFlag_i            - exception flush
//   enq_en_i/pc/brType         - enqueue request from fetch-2
//   enq_id_o                   - slot the next enqueue takes
//   full_o                     - queue full, fetch-2 stalls
//   commit_i                   - oldest uncommitted CTI retired
//   underflow_o                - registered pulse: commit with nothing to commit
//   updateEn_o/BrType_o/PC_o   - registered predictor update
module cti_commit_queue
  import cti_commit_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = CTI_DEPTH,
  parameter int unsigned INDEX    = CTI_INDEX,
  parameter int unsigned PC_W     = SIZE_PC,
  parameter int unsigned BRTYPE_W = BRANCH_TYPE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                recoverFlag_i,
  input  logic                exceptionFlag_i,
  input  logic                enq_en_i,
  input  logic [PC_W-1:0]     enq_pc_i,
  input  logic [BRTYPE_W-1:0] enq_brType_i,
  output logic [INDEX-1:0]    enq_id_o,
  output logic                full_o,
  input  logic                commit_i,
  output logic                underflow_o,
  output logic                updateEn_o,
  output logic [BRTYPE_W-1:0] updateBrType_o,
  output logic [PC_W-1:0]     updatePC_o
);

  localparam int unsigned    EntryW   = PC_W + BRTYPE_W;
  localparam logic [INDEX:0] DepthPtr = {1'b1, {INDEX{1'b0}}};
  localparam logic [INDEX:0] PtrOne   = {{INDEX{1'b0}}, 1'b1};

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [INDEX:0] head_q, head_d;
  logic [INDEX:0] cmt_q, cmt_d;
  logic [INDEX:0] tail_q, tail_d;
  logic [INDEX:0] total, committed;

  logic flush, full, enq_ok, cmt_ok, drain;
  logic [EntryW-1:0] rd_data;

  logic                upd_en_q, upd_en_d;
  logic [PC_W-1:0]     upd_pc_q, upd_pc_d;
  logic [BRTYPE_W-1:0] upd_bt_q, upd_bt_d;
  logic                underflow_q, underflow_d;

  always_comb begin
    flush     = recoverFlag_i | exceptionFlag_i;
    total     = tail_q - head_q;
    committed = cmt_q - head_q;
    full      = (total == DepthPtr);
    // Full is judged on registered state, so a same-cycle drain never makes room.
    enq_ok    = enq_en_i & ~full & ~flush;
    cmt_ok    = commit_i & (cmt_q != tail_q);
    drain     = (committed != '0);

    cmt_d  = cmt_ok ? (cmt_q + PtrOne) : cmt_q;
    // A flush rolls the tail back to the post-commit point, dropping speculation.
    tail_d = flush ? cmt_d : (enq_ok ? (tail_q + PtrOne) : tail_q);
    head_d = drain ? (head_q + PtrOne) : head_q;

    upd_en_d    = drain;
    upd_pc_d    = drain ? rd_data[EntryW-1:BRTYPE_W] : upd_pc_q;
    upd_bt_d    = drain ? rd_data[BRTYPE_W-1:0] : upd_bt_q;
    underflow_d = commit_i & (cmt_q == tail_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q      <= '0;
      cmt_q       <= '0;
      tail_q      <= '0;
      upd_en_q    <= 1'b0;
      upd_pc_q    <= '0;
      upd_bt_q    <= '0;
      underflow_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      cmt_q       <= cmt_d;
      tail_q      <= tail_d;
      upd_en_q    <= upd_en_d;
      upd_pc_q    <= upd_pc_d;
      upd_bt_q    <= upd_bt_d;
      underflow_q <= underflow_d;
    end
  end

  cti_queue_ram #(
    .DEPTH (DEPTH),
    .INDEX (INDEX),
    .WIDTH (EntryW)
  ) u_ram (
    .clk     (clk),
    .we_i    (enq_ok & ~reset),
    .waddr_i (tail_q[INDEX-1:0]),
    .wdata_i ({enq_pc_i, enq_brType_i}),
    .raddr_i (head_q[INDEX-1:0]),
    .rdata_o (rd_data)
  );

  assign enq_id_o       = tail_q[INDEX-1:0];
  assign full_o         = full;
  assign underflow_o    = underflow_q;
  assign updateEn_o     = upd_en_q;
  assign updatePC_o     = upd_pc_q;
  assign updateBrType_o = upd_bt_q;

endmodule

// File: tb/tb_cti_commit_queue.sv
module tb_cti_commit_queue;
  import cti_commit_queue_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        recover = 1'b0;
  logic        exc = 1'b0;
  logic        enq_en = 1'b0;
  logic [31:0] enq_pc = '0;
  logic [1:0]  enq_bt = '0;
  logic        commit = 1'b0;
  logic [3:0]  enq_id;
  logic        full;
  logic        underflow;
  logic        upd_en;
  logic [1:0]  upd_bt;
  logic [31:0] upd_pc;

  int tests_run = 0;
  int failures  = 0;

  // spec_q: enqueued but uncommitted; exp_q: committed, awaiting update output.
  cti_entry_t spec_q[$];
  cti_entry_t exp_q[$];

  cti_commit_queue dut (
    .clk             (clk),
    .reset           (reset),
    .recoverFlag_i   (recover),
    .exceptionFlag_i (exc),
    .enq_en_i        (enq_en),
    .enq_pc_i        (enq_pc),
    .enq_brType_i    (enq_bt),
    .enq_id_o        (enq_id),
    .full_o          (full),
    .commit_i        (commit),
    .underflow_o     (underflow),
    .updateEn_o      (upd_en),
    .updateBrType_o  (upd_bt),
    .updatePC_o      (upd_pc)
  );

  always #5 clk = ~clk;

  // Scoreboard: every update must match the oldest committed entry.
  always @(negedge clk) begin
    cti_entry_t e;
    if (upd_en !== 1'b0) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL update_unexpected: got en=%b pc=%h bt=%0d, required none",
                 upd_en, upd_pc, upd_bt);
      end else begin
        e = exp_q.pop_front();
        if (upd_en !== 1'b1 || upd_pc !== e.pc || upd_bt !== e.br_type) begin
          failures++;
          $display("FAIL update_order: got en=%b pc=%h bt=%0d, required pc=%h bt=%0d",
                   upd_en, upd_pc, upd_bt, e.pc, e.br_type);
        end
      end
    end
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1; enq_en = 1'b0; commit = 1'b0; recover = 1'b0; exc = 1'b0;
    step();
    step();
    reset = 1'b0;
    spec_q.delete();
    exp_q.delete();
  endtask

  task automatic enq(input logic [31:0] pc, input logic [1:0] bt, input bit accept);
    cti_entry_t e;
    enq_en = 1'b1; enq_pc = pc; enq_bt = bt;
    e.pc = pc; e.br_type = bt;
    if (accept) spec_q.push_back(e);
    step();
    enq_en = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    if (spec_q.size() != 0) exp_q.push_back(spec_q.pop_front());
    step();
    commit = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    for (int i = 0; i < 4; i++) step();
    tests_run++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: %0d updates still pending, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset_dut();
    tests_run++;
    if (upd_en !== 1'b0 || upd_pc !== 32'h0 || upd_bt !== 2'd0 || underflow !== 1'b0 ||
        full !== 1'b0 || enq_id !== 4'd0) begin
      failures++;
      $display("FAIL reset_state: en=%b pc=%h bt=%0d uf=%b full=%b id=%0d, required all 0",
               upd_en, upd_pc, upd_bt, underflow, full, enq_id);
    end
  endtask

  task automatic test_single();
    reset_dut();
    enq(32'h400, CALL, 1'b1);          // t0
    do_commit();                       // t1
    step();                            // t2 -> now t3
    tests_run++;
    if (upd_en !== 1'b1 || upd_pc !== 32'h400 || upd_bt !== CALL) begin
      failures++;
      $display("FAIL single_latency: en=%b pc=%h bt=%0d, required en=1 pc=400 bt=%0d",
               upd_en, upd_pc, upd_bt, CALL);
    end
    step();                            // t4
    tests_run++;
    if (upd_en !== 1'b0 || upd_pc !== 32'h400 || upd_bt !== CALL) begin
      failures++;
      $display("FAIL single_hold: en=%b pc=%h bt=%0d, required en=0 pc=400 bt=%0d",
               upd_en, upd_pc, upd_bt, CALL);
    end
    wait_drain("single");
  endtask

  task automatic test_full();
    reset_dut();
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        tests_run++;
        if (full !== 1'b0) begin
          failures++;
          $display("FAIL full_early: full=%b after 15 enqueues, required 0", full);
        end
      end
      enq(32'h2000 + 32'(i * 4), 2'(i), 1'b1);
    end
    tests_run++;
    if (full !== 1'b1 || enq_id !== 4'd0) begin
      failures++;
      $display("FAIL full_set: full=%b id=%0d, required full=1 id=0", full, enq_id);
    end
    enq(32'hBEEF, JUMP, 1'b0);
    tests_run++;
    if (full !== 1'b1 || enq_id !== 4'd0) begin
      failures++;
      $display("FAIL full_drop: full=%b id=%0d, required full=1 id=0", full, enq_id);
    end
    for (int i = 0; i < 16; i++) do_commit();
    wait_drain("full");
    tests_run++;
    if (full !== 1'b0) begin
      failures++;
      $display("FAIL full_clear: full=%b after drain, required 0", full);
    end
  endtask

  task automatic test_flush();
    reset_dut();
    enq(32'hA0, CALL, 1'b1);
    enq(32'hB0, RETURN, 1'b1);
    enq(32'hC0, JUMP, 1'b1);
    do_commit();
    // Recover, commit and a doomed enqueue all in one cycle.
    recover = 1'b1; commit = 1'b1; enq_en = 1'b1; enq_pc = 32'hDEAD; enq_bt = COND;
    exp_q.push_back(spec_q.pop_front());
    spec_q.delete();
    step();
    recover = 1'b0; commit = 1'b0; enq_en = 1'b0;
    tests_run++;
    if (enq_id !== 4'd2) begin
      failures++;
      $display("FAIL flush_tail: id=%0d, required 2", enq_id);
    end
    enq(32'hD0, COND, 1'b1);
    do_commit();
    wait_drain("flush");
    enq(32'hE0, CALL, 1'b1);
    enq(32'hF0, CALL, 1'b1);
    exc = 1'b1;
    spec_q.delete();
    step();
    exc = 1'b0;
    tests_run++;
    if (enq_id !== 4'd3) begin
      failures++;
      $display("FAIL exception_tail: id=%0d, required 3", enq_id);
    end
    do_commit();                       // nothing left to commit
    wait_drain("exception");
  endtask

  task automatic test_underflow();
    reset_dut();
    commit = 1'b1;
    step();
    commit = 1'b0;
    tests_run++;
    if (underflow !== 1'b1 || upd_en !== 1'b0) begin
      failures++;
      $display("FAIL underflow_pulse: uf=%b en=%b, required uf=1 en=0", underflow, upd_en);
    end
    step();
    tests_run++;
    if (underflow !== 1'b0 || enq_id !== 4'd0 || upd_en !== 1'b0) begin
      failures++;
      $display("FAIL underflow_end: uf=%b id=%0d en=%b, required uf=0 id=0 en=0",
               underflow, enq_id, upd_en);
    end
    enq(32'h77C, RETURN, 1'b1);
    do_commit();
    wait_drain("underflow");
  endtask

  task automatic test_back_to_back();
    bit saw_full = 1'b0;
    cti_entry_t e;
    reset_dut();
    // Cycle k enqueues entry k and commits entry k-1.
    for (int k = 0; k <= 40; k++) begin
      enq_en = (k < 40);
      commit = (k > 0);
      enq_pc = 32'h1000 + 32'(8 * k);
      enq_bt = 2'(k);
      if (commit) exp_q.push_back(spec_q.pop_front());
      if (enq_en) begin
        e.pc = enq_pc; e.br_type = enq_bt;
        spec_q.push_back(e);
      end
      step();
      if (full !== 1'b0) saw_full = 1'b1;
    end
    enq_en = 1'b0; commit = 1'b0;
    wait_drain("wrap");
    tests_run++;
    if (saw_full !== 1'b0 || enq_id !== 4'd8) begin
      failures++;
      $display("FAIL wrap_state: saw_full=%b id=%0d, required saw_full=0 id=8",
               saw_full, enq_id);
    end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    enq(32'h3000, CALL, 1'b1);
    enq(32'h3008, RETURN, 1'b1);
    enq(32'h3010, JUMP, 1'b1);
    do_commit();
    do_commit();
    do_commit();
    reset = 1'b1;
    step();
    reset = 1'b0;
    spec_q.delete();
    exp_q.delete();
    tests_run++;
    if (upd_en !== 1'b0 || enq_id !== 4'd0 || full !== 1'b0 || upd_pc !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid: en=%b id=%0d full=%b pc=%h, required en=0 id=0 full=0 pc=0",
               upd_en, enq_id, full, upd_pc);
    end
    wait_drain("reset_mid");
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_flush();
    test_underflow();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/cti_commit_queue.md
Name: cti_commit_queue

Overview:
- In-order queue of control-transfer instructions (CTIs) that sits between fetch-2 and retire.
- Fetch-2 enqueues each fetched CTI (PC, branch type) speculatively; retire marks entries committed in program order.
- Committed entries drain one per cycle onto the predictor update bus (updateEn/updateBrType/updatePC), which drives the non-speculative RAS top-of-stack and its architectural push.
- Recovery and exceptions discard all uncommitted entries.

Parameters:
DEPTH, 16, number of queue entries (power of two)
INDEX, 4, log2(DEPTH)
PC_W, `SIZE_PC, PC width
BRTYPE_W, `BRANCH_TYPE, branch-type field width

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
recoverFlag_i  input  1  branch-mispredict flush
exceptionFlag_i  input  1  exception flush
enq_en_i  input  1  fetch-2 enqueues a CTI this cycle
enq_pc_i  input  PC_W  PC of the enqueued CTI
enq_brType_i  input  BRTYPE_W  branch type (`CALL, `RETURN, ...)
enq_id_o  output  INDEX  slot index the next enqueue will take (current tail)
full_o  output  1  queue full; fetch-2 must stall
commit_i  input  1  oldest uncommitted CTI retired this cycle
underflow_o  output  1  pulse: commit_i arrived with no uncommitted entry
updateEn_o  output  1  predictor/RAS update valid
updateBrType_o  output  BRTYPE_W  branch type of the update
updatePC_o  output  PC_W  PC of the updated CTI

Behaviour:
- Clock and reset: one clock (clk). reset is synchronous and active-high.
- State:
  - Pointers head (oldest), cmt (next to commit) and tail, each INDEX+1 bits. The MSB is the wrap bit; the low INDEX bits index storage.
  - Invariant: head <= cmt <= tail, modulo wrap.
- Occupancy and flags:
  - total = tail - head; committed = cmt - head (both INDEX+1 bits).
  - full_o = (total == DEPTH), derived combinationally from registered state only.
  - enq_id_o = tail[INDEX-1:0].
- Reset: all pointers = 0; updateEn_o = 0; updatePC_o = 0; updateBrType_o = 0; underflow_o = 0; full_o = 0. Reset overrides all other inputs.
- Enqueue:
  - Accepted iff enq_en_i & ~full_o & ~recoverFlag_i & ~exceptionFlag_i.
  - Writes {pc, brType} at tail; tail increments by 1.
  - Enqueue while full is dropped silently. A drain in the same cycle does not make room.
- Commit:
  - Accepted iff commit_i & (cmt != tail); cmt increments by 1.
  - If cmt == tail: commit is ignored and underflow_o = 1 next cycle (registered, one-cycle pulse).
  - A commit in the same cycle as a flush is still honoured.
- Drain:
  - If committed != 0, read entry at head; head increments by 1. Outputs are registered: updateEn_o = 1 with that entry's fields next cycle. Otherwise updateEn_o = 0.
  - Updates carry no backpressure; at most one per cycle.
  - Latency: commit in cycle t -> entry committed at t+1 -> update visible on outputs at t+2.
  - updatePC_o and updateBrType_o hold their last values while updateEn_o = 0.
- Flush (recoverFlag_i | exceptionFlag_i):
  - Next tail = next cmt, i.e. after this cycle's commit.
  - Committed entries are kept and continue draining.
  - Enqueue in the flush cycle is dropped.
- Simultaneous events: enqueue, commit and drain may all occur in one cycle; each pointer updates independently.
- Wrap-around: pointers wrap naturally at 2*DEPTH. Full/empty is distinguished by the wrap bit.
- Storage: 1R1W array, DEPTH x (PC_W + BRTYPE_W). Write at tail, read at head, same cycle allowed (different slots whenever committed != 0).

Decomposition:
- Shared package: branch-type constants (`CALL, `RETURN, `JUMP, `COND), `SIZE_PC, `BRANCH_TYPE, queue DEPTH/INDEX, and a packed struct cti_entry_t {pc, brType}.
- Sub-module cti_queue_ram: 1R1W storage. Synchronous write; combinational read at head, registered into the output stage by the parent.

Test Plan:
- Enqueue {0x400, CALL} at t0; commit_i at t1 -> updateEn_o = 1, updatePC_o = 0x400, updateBrType_o = CALL at t3; updateEn_o = 0 at t4.
- 16 back-to-back enqueues with no commits -> full_o = 1 after the 16th. A 17th enqueue of 0xBEEF is dropped. After 16 commits, exactly 16 updates emerge in order; 0xBEEF never appears.
- Enqueue A, B, C; commit A; assert recoverFlag_i with commit_i in the same cycle -> updates A then B only. enq_id_o returns to 2. The next enqueue D is emitted after B once committed.
- commit_i with queue empty -> underflow_o = 1 for exactly one cycle; pointers unchanged; updateEn_o stays 0.
- 40 enqueue/commit pairs, PCs 0x1000 + 8k -> 40 updates, strictly in order, across pointer wrap. full_o never asserts.
- Enqueue and commit 3 entries, then assert reset before the drain completes -> updateEn_o = 0 the next cycle; enq_id_o = 0; full_o = 0. No stale update appears afterwards.
